max_pool_win_gen: RTL and testbench
===================================

MAX_POOL_WIN_GEN -- requirements
Module: max_pool_win_gen

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, is the width of one signed sample.
- REQ-002: Parameter WIN_SIZE, default 3, is the pooling window edge in samples.
- REQ-003: Parameter STRIDE, default 3, is the window step in columns and in rows.
- REQ-004: Parameter IMG_WIDTH, default 16, is the number of samples per image row.
- REQ-005: Parameter IMG_HEIGHT, default 16, is the number of rows per frame.
- REQ-006: Port clk, input, 1 bit, is the single clock; all logic runs on its rising edge.
- REQ-007: Port reset_n, input, 1 bit, is the reset: synchronous, active-low.
- REQ-008: Port fin_start, input, 1 bit, marks the first sample of a frame; it is qualified by din_vld.
- REQ-009: Port din_vld, input, 1 bit, qualifies din; there is no backpressure.
- REQ-010: Port din, input, signed DATA_WIDTH bits, carries one sample in raster order.
- REQ-011: Port fout_start, output, 1 bit, is high together with win_vld for the first window of a frame.
- REQ-012: Port win_vld, output, 1 bit, is a single-cycle strobe qualifying win.
- REQ-013: Port win, output, signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0], is the window; win[r][c] has r=0 as the top (oldest) row and c=0 as the leftmost column.

Function
- REQ-014: The block shall hold WIN_SIZE-1 line buffers of IMG_WIDTH samples each, plus a WIN_SIZE-deep column shift register per window row.
- REQ-015: A two-state FSM shall have states IDLE and ACTIVE; IDLE moves to ACTIVE on a beat with din_vld=1 and fin_start=1; ACTIVE moves to IDLE on the beat that accepts sample (IMG_HEIGHT-1, IMG_WIDTH-1).
- REQ-016: In IDLE, beats with fin_start=0 shall be discarded, and fin_start with din_vld=0 shall be ignored in every state.
- REQ-017: The fin_start beat shall be sample (0,0); col and row counters shall then advance per accepted beat, with col wrapping at IMG_WIDTH-1 to 0 and incrementing row.
- REQ-018: fin_start=1 with din_vld=1 in ACTIVE shall abandon the current frame, restart at (0,0), and produce no window from stale rows.
- REQ-019: A window shall be emitted for the beat at (row,col) iff row>=WIN_SIZE-1, col>=WIN_SIZE-1, (row-WIN_SIZE+1)%STRIDE==0 and (col-WIN_SIZE+1)%STRIDE==0.
- REQ-020: The stride conditions shall be implemented with phase counters, not dividers.
- REQ-021: win_vld shall rise exactly 1 cycle after the completing din_vld beat; win shall hold rows row-WIN_SIZE+1..row and columns col-WIN_SIZE+1..col.
- REQ-022: win shall keep its last value while win_vld=0.
- REQ-023: fout_start shall be high only together with the first win_vld after each accepted fin_start.
- REQ-024: Gaps in din_vld of any length shall not alter window contents or count; throughput shall be one sample per cycle.
- REQ-025: Windows per frame shall be ((IMG_HEIGHT-WIN_SIZE)/STRIDE+1)*((IMG_WIDTH-WIN_SIZE)/STRIDE+1), using integer division.
- REQ-026: Samples shall pass unmodified; no arithmetic shall be applied to data.

Reset
- REQ-027: While reset_n=0 at a clk edge: FSM to IDLE, counters to 0, win_vld=0, fout_start=0, win=0.
- REQ-028: Line buffer contents need not reset; reset mid-frame shall discard the frame, and no window shall be emitted until a new fin_start.

Verification
- REQ-029: Parameters IMG 6x6, WIN_SIZE=3, STRIDE=3; stream sample value row*6+col continuously. Required response:
  - first win_vld is 1 cycle after sample 14, with fout_start=1;
  - win[0]={0,1,2}, win[1]={6,7,8}, win[2]={12,13,14};
  - exactly 4 windows, at samples 14, 17, 32 and 35.
- REQ-030: Same stream as REQ-029 with din_vld toggled randomly at 50% -> identical 4 windows and contents; each win_vld arrives 1 cycle after its completing beat.
- REQ-031: Same parameters with STRIDE=1 -> 16 windows; the last window is win[0]={21,22,23}, win[1]={27,28,29}, win[2]={33,34,35}.
- REQ-032: fin_start re-asserted at sample 20 of the frame, then a full frame streamed -> no window from the aborted frame after the restart; the next 4 windows match REQ-029 and the first has fout_start=1.
- REQ-033: reset_n low for 1 cycle at sample 15 -> outputs are 0 the next cycle; samples without a fin_start are ignored; the following frame matches REQ-029.
- REQ-034: Two back-to-back frames with no idle cycle -> 8 windows; fout_start is high exactly twice.

Source files
------------

// File: rtl/max_pool_win_gen.sv
// Raster-scan pooling window generator: line buffers feed per-row column
// shift registers, and strided windows are emitted on completing beats.
module max_pool_win_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 3,
  parameter int STRIDE     = 3,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fin_start,
  input  logic                         din_vld,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         fout_start,
  output logic                         win_vld,
  output logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win
);

  localparam int W  = WIN_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [PW-1:0]    cph_q, cph_d, cur_cph;
  logic [PW-1:0]    rph_q, rph_d, cur_rph;
  logic             first_q, first_d;
  logic             restart, acc, emit, last_col, last_row;
  logic             fout_q, win_vld_q;

  logic signed [DW-1:0] lb_q [W-1][IMG_WIDTH];
  logic signed [W-1:0][W-1:0][DW-1:0] sr_q, win_q, win_d;
  logic signed [W-1:0][DW-1:0] colv;

  assign fout_start = fout_q;
  assign win_vld    = win_vld_q;
  assign win        = win_q;

  always_comb begin
    restart  = din_vld & fin_start;
    acc      = din_vld & (fin_start | (state_q == ACTIVE));
    cur_col  = restart ? '0 : col_q;
    cur_row  = restart ? '0 : row_q;
    cur_cph  = restart ? '0 : cph_q;
    cur_rph  = restart ? '0 : rph_q;
    last_col = cur_col == CW'(IMG_WIDTH - 1);
    last_row = cur_row == RW'(IMG_HEIGHT - 1);
    emit     = (cur_row >= RW'(W - 1)) && (cur_col >= CW'(W - 1))
             && (cur_rph == '0) && (cur_cph == '0);
    col_d    = cur_col + 1'b1;
    row_d    = cur_row;
    cph_d    = cur_cph;
    rph_d    = cur_rph;
    state_d  = ACTIVE;
    if (cur_col >= CW'(W - 1))
      cph_d = (cur_cph == PW'(STRIDE - 1)) ? '0 : cur_cph + 1'b1;
    if (last_col) begin
      col_d = '0;
      cph_d = '0;
      row_d = cur_row + 1'b1;
      if (cur_row >= RW'(W - 1))
        rph_d = (cur_rph == PW'(STRIDE - 1)) ? '0 : cur_rph + 1'b1;
      if (last_row) begin
        row_d   = '0;
        rph_d   = '0;
        state_d = IDLE;
      end
    end
    first_d = (restart | first_q) & ~emit;
  end

  // Column entering the window: oldest line buffer on top, live sample last.
  always_comb begin
    colv = '0;
    for (int r = 0; r < W - 1; r++)
      colv[r] = lb_q[W-2-r][cur_col];
    colv[W-1] = din;
    win_d = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W - 1; c++)
        win_d[r][c] = sr_q[r][c+1];
      win_d[r][W-1] = colv[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cph_q     <= '0;
      rph_q     <= '0;
      first_q   <= 1'b0;
      fout_q    <= 1'b0;
      win_vld_q <= 1'b0;
      win_q     <= '0;
    end else begin
      win_vld_q <= acc & emit;
      fout_q    <= acc & emit & (restart | first_q);
      if (acc) begin
        state_q <= state_d;
        col_q   <= col_d;
        row_q   <= row_d;
        cph_q   <= cph_d;
        rph_q   <= rph_d;
        first_q <= first_d;
        if (emit)
          win_q <= win_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb_q[0][cur_col] <= din;
      for (int k = 1; k < W - 1; k++)
        lb_q[k][cur_col] <= lb_q[k-1][cur_col];
      sr_q <= win_d;
    end
  end

endmodule

// File: tb/tb_max_pool_win_gen.sv
// Directed bench for max_pool_win_gen on a 6x6 image, stride 3 and stride 1.
module tb_max_pool_win_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic fin_start;
  logic din_vld;
  logic signed [7:0] din;
  logic fout0, wv0, fout1, wv1;
  logic signed [2:0][2:0][7:0] win0, win1;

  typedef struct {
    int         s;
    bit         v;
    bit         f;
    logic [71:0] w;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  logic       ld_vld;
  logic [7:0] ld_din;
  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  max_pool_win_gen #(
    .DATA_WIDTH(8), .WIN_SIZE(3), .STRIDE(3),
    .IMG_WIDTH(6), .IMG_HEIGHT(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fin_start(fin_start),
    .din_vld(din_vld), .din(din),
    .fout_start(fout0), .win_vld(wv0), .win(win0)
  );

  max_pool_win_gen #(
    .DATA_WIDTH(8), .WIN_SIZE(3), .STRIDE(1),
    .IMG_WIDTH(6), .IMG_HEIGHT(6)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .fin_start(fin_start),
    .din_vld(din_vld), .din(din),
    .fout_start(fout1), .win_vld(wv1), .win(win1)
  );

  always @(posedge clk) begin
    ld_vld <= din_vld;
    ld_din <= din;
  end

  always @(negedge clk) begin
    if (wv0) q0.push_back('{int'(ld_din), ld_vld, fout0, 72'(win0)});
    if (wv1) q1.push_back('{int'(ld_din), ld_vld, fout1, 72'(win1)});
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int s);
    logic [71:0] w;
    int r, c;
    r = s / 6;
    c = s % 6;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 6 + (c - 2 + j));
    return w;
  endfunction

  task automatic check_rec(input string tag, input rec_t rc,
                           input int s, input bit f);
    chk({tag, " sample"}, rc.s, s);
    chk({tag, " win"}, rc.w, exp_win(s));
    chk({tag, " fout"}, rc.f, f);
    chk({tag, " latency"}, rc.v, 1);
  endtask

  task automatic check4(input string tag, input int base);
    int smp[4] = '{14, 17, 32, 35};
    for (int k = 0; k < 4; k++)
      if (base + k < q0.size())
        check_rec($sformatf("%s w%0d", tag, k), q0[base+k], smp[k], k == 0);
  endtask

  task automatic drive(input bit v, input bit f, input logic [7:0] d);
    din_vld   = v;
    fin_start = f;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input bit gaps);
    for (int s = 0; s < 36; s++) begin
      if (gaps)
        while ($urandom_range(0, 1) == 1)
          drive(1'b0, 1'($urandom_range(0, 1)), 8'hAA);
      drive(1'b1, s == 0, 8'(s));
    end
  endtask

  task automatic flush();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr();
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int nf;
    reset_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst win_vld", wv0, 0);
    chk("rst fout", fout0, 0);
    chk("rst win", win0, 0);

    clr();
    stream(1'b0);
    flush();
    chk("cont cnt", q0.size(), 4);
    check4("cont", 0);
    chk("s1 cnt", q1.size(), 16);
    if (q1.size() == 16) begin
      check_rec("s1 first", q1[0], 14, 1'b1);
      check_rec("s1 last", q1[15], 35, 1'b0);
    end

    clr();
    stream(1'b1);
    flush();
    chk("gap cnt", q0.size(), 4);
    check4("gap", 0);

    clr();
    for (int s = 0; s < 20; s++) drive(1'b1, s == 0, 8'(s));
    stream(1'b0);
    flush();
    chk("abort cnt", q0.size(), 6);
    if (q0.size() >= 2) begin
      check_rec("abort old0", q0[0], 14, 1'b1);
      check_rec("abort old1", q0[1], 17, 1'b0);
    end
    check4("abort new", 2);

    clr();
    for (int s = 0; s < 15; s++) drive(1'b1, s == 0, 8'(s));
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 8'd15);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst win_vld", wv0, 0);
    chk("mrst fout", fout0, 0);
    chk("mrst win", win0, 0);
    for (int s = 16; s < 36; s++) drive(1'b1, 1'b0, 8'(s));
    stream(1'b0);
    flush();
    chk("mrst cnt", q0.size(), 5);
    if (q0.size() >= 1) check_rec("mrst pre", q0[0], 14, 1'b1);
    check4("mrst new", 1);

    clr();
    stream(1'b0);
    stream(1'b0);
    flush();
    chk("b2b cnt", q0.size(), 8);
    nf = 0;
    foreach (q0[k]) nf += int'(q0[k].f);
    chk("b2b fout cnt", nf, 2);
    check4("b2b f0", 0);
    check4("b2b f1", 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
